// File: rtl/mem_copy_pkg.sv
// Shared types and constants for the block copy / fill engine.
package mem_copy_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic {
    MODE_COPY = 1'b0,
    MODE_FILL = 1'b1
  } mode_e;

  // Cycles from a sampled mem_re to valid mem_rdata.
  localparam int READ_LATENCY = 1;

endpackage

// File: rtl/mem_copy_engine.sv
// Test/boot DMA: copies LEN words from SRC to DST, or fills LEN words at DST
// with a constant. One word per cycle. Each issued read is written to its
// destination in the cycle its data returns. Control outputs are registered.
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int AWIDTH = 16,
  parameter int DWIDTH = 16,
  parameter int LWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [AWIDTH-1:0] src_addr,
  input  logic [AWIDTH-1:0] dst_addr,
  input  logic [LWIDTH-1:0] len,
  input  logic [DWIDTH-1:0] fill_data,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              mem_re,
  output logic [AWIDTH-1:0] mem_raddr,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_waddr,
  output logic [DWIDTH-1:0] mem_wdata
);

  state_e                  state_q, state_d;
  mode_e                   mode_q, mode_d;
  logic                    desc_q, desc_d;
  logic [DWIDTH-1:0]       fill_q, fill_d;
  logic [LWIDTH-1:0]       cnt_q, cnt_d;
  logic [AWIDTH-1:0]       src_ptr_q, src_ptr_d;
  logic [AWIDTH-1:0]       dst_ptr_q, dst_ptr_d;
  // Write-valid and write-address for the read currently in flight.
  logic [READ_LATENCY-1:0] wv_q, wv_d;
  logic [AWIDTH-1:0]       pend_waddr_q, pend_waddr_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    aborted_q, aborted_d;
  logic                    re_q, re_d;
  logic [AWIDTH-1:0]       raddr_q, raddr_d;
  logic                    we_q, we_d;
  logic [AWIDTH-1:0]       waddr_q, waddr_d;

  logic                    last_issue;
  logic                    start_desc;
  logic [AWIDTH-1:0]       len_m1;

  assign last_issue = (cnt_q == LWIDTH'(1));
  // A forward-overlapping copy must walk from the top down so no source word
  // is overwritten before it has been read.
  assign start_desc = (mode_e'(mode) == MODE_COPY) && (dst_addr > src_addr);
  assign len_m1     = AWIDTH'(len) - AWIDTH'(1);

  // State and datapath registers; synchronous reset drops any transfer.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q      <= IDLE;
      mode_q       <= MODE_COPY;
      desc_q       <= 1'b0;
      fill_q       <= '0;
      cnt_q        <= '0;
      src_ptr_q    <= '0;
      dst_ptr_q    <= '0;
      wv_q         <= '0;
      pend_waddr_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      re_q         <= 1'b0;
      raddr_q      <= '0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      desc_q       <= desc_d;
      fill_q       <= fill_d;
      cnt_q        <= cnt_d;
      src_ptr_q    <= src_ptr_d;
      dst_ptr_q    <= dst_ptr_d;
      wv_q         <= wv_d;
      pend_waddr_q <= pend_waddr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      re_q         <= re_d;
      raddr_q      <= raddr_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: assigning a default before the case keeps every path assigned, so
    // no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = (len == '0) ? DONE : RUN;
      RUN: begin
        if (abort)           state_d = DONE;
        else if (last_issue) state_d = (mode_q == MODE_FILL) ? DONE : DRAIN;
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values: issue reads/writes, step pointers.
  always_comb begin
    mode_d       = mode_q;
    desc_d       = desc_q;
    fill_d       = fill_q;
    cnt_d        = cnt_q;
    src_ptr_d    = src_ptr_q;
    dst_ptr_d    = dst_ptr_q;
    wv_d         = '0;
    pend_waddr_d = pend_waddr_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    aborted_d    = aborted_q;
    re_d         = 1'b0;
    raddr_d      = raddr_q;
    we_d         = 1'b0;
    waddr_d      = waddr_q;

    // Complete the in-flight copy read; abort discards its data.
    if (wv_q[READ_LATENCY-1] && !abort) begin
      we_d    = 1'b1;
      waddr_d = pend_waddr_q;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          busy_d    = 1'b1;
          aborted_d = 1'b0;
          mode_d    = mode_e'(mode);
          fill_d    = fill_data;
          cnt_d     = len;
          desc_d    = start_desc;
          src_ptr_d = start_desc ? src_addr + len_m1 : src_addr;
          dst_ptr_d = start_desc ? dst_addr + len_m1 : dst_addr;
        end
      end
      RUN: begin
        if (abort) begin
          aborted_d = 1'b1;
        end else begin
          cnt_d     = cnt_q - LWIDTH'(1);
          src_ptr_d = desc_q ? src_ptr_q - AWIDTH'(1) : src_ptr_q + AWIDTH'(1);
          dst_ptr_d = desc_q ? dst_ptr_q - AWIDTH'(1) : dst_ptr_q + AWIDTH'(1);
          if (mode_q == MODE_COPY) begin
            re_d         = 1'b1;
            raddr_d      = src_ptr_q;
            wv_d[0]      = 1'b1;
            pend_waddr_d = dst_ptr_q;
          end else begin
            we_d    = 1'b1;
            waddr_d = dst_ptr_q;
          end
        end
      end
      DRAIN: begin
        if (abort) aborted_d = 1'b1;
      end
      DONE: begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign mem_re    = re_q;
  assign mem_raddr = raddr_q;
  assign mem_we    = we_q;
  assign mem_waddr = waddr_q;
  // Copy data passes straight from the read port so the write lands in the
  // cycle the data returns; zero whenever no write is active.
  assign mem_wdata = !we_q ? '0 : (mode_q == MODE_FILL) ? fill_q : mem_rdata;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine with a behavioural 64K-word memory.
module tb_mem_copy_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] src_addr = '0;
  logic [15:0] dst_addr = '0;
  logic [15:0] len = '0;
  logic [15:0] fill_data = '0;
  logic        abort = 1'b0;
  logic        busy, done, aborted;
  logic        mem_re, mem_we;
  logic [15:0] mem_raddr, mem_waddr, mem_wdata;
  logic [15:0] mem_rdata = '0;

  logic        pre_we = 1'b0;
  logic [15:0] pre_addr = '0;
  logic [15:0] pre_data = '0;
  logic [15:0] mem [0:65535];

  logic [15:0] wr_addr_log [$];
  int          rd_cnt = 0;
  int          done_cnt = 0;
  int          ovl_cnt = 0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_copy_engine dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .len       (len),
    .fill_data (fill_data),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .mem_re    (mem_re),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata)
  );

  // Memory: write-first, a same-cycle read of the written address sees new data.
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (mem_re)
      mem_rdata <= (mem_we && mem_waddr == mem_raddr) ? mem_wdata : mem[mem_raddr];
  end

  // Traffic monitor.
  always @(posedge clk) begin
    if (mem_we) wr_addr_log.push_back(mem_waddr);
    if (mem_re) rd_cnt <= rd_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (done && busy) ovl_cnt <= ovl_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Returns at the negedge of the first cycle after the accept edge.
  task automatic launch(input logic m, input logic [15:0] s, input logic [15:0] d,
                        input logic [15:0] l, input logic [15:0] f);
    @(negedge clk);
    start = 1'b1; mode = m; src_addr = s; dst_addr = d; len = l; fill_data = f;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int busy_cyc, output bit got, output bit prev_we);
    busy_cyc = 0; got = 1'b0; prev_we = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      if (done) got = 1'b1;
      else begin
        if (busy) busy_cyc++;
        prev_we = mem_we;
        @(negedge clk);
      end
    end
  endtask

  int          bc;
  bit          got, pw;
  int          wbase, rbase, dbase, nre;
  logic [15:0] exp_a [4];

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_aborted", aborted, 0);
    check("rst_re", mem_re, 0);
    check("rst_we", mem_we, 0);
    check("rst_raddr", mem_raddr, 0);
    check("rst_waddr", mem_waddr, 0);
    check("rst_wdata", mem_wdata, 0);
    rst = 1'b0;

    // Plain copy, dst above src (descending walk).
    poke(16'h0100, 16'hA0A0); poke(16'h0101, 16'hB1B1);
    poke(16'h0102, 16'hC2C2); poke(16'h0103, 16'hD3D3);
    wbase = wr_addr_log.size(); rbase = rd_cnt;
    launch(1'b0, 16'h0100, 16'h0200, 16'd4, 16'h0);
    wait_done(bc, got, pw);
    check("copy_done_seen", got, 1);
    check("copy_busy_cycles", bc, 6);
    check("copy_write_before_done", pw, 1);
    check("copy_aborted", aborted, 0);
    check("copy_m200", mem[16'h0200], 16'hA0A0);
    check("copy_m201", mem[16'h0201], 16'hB1B1);
    check("copy_m202", mem[16'h0202], 16'hC2C2);
    check("copy_m203", mem[16'h0203], 16'hD3D3);
    @(negedge clk);
    check("copy_done_one_cycle", done, 0);
    check("copy_reads", rd_cnt - rbase, 4);
    check("copy_writes", wr_addr_log.size() - wbase, 4);

    // Forward-overlapping copy: must write top-down.
    poke(16'h0010, 16'd1); poke(16'h0011, 16'd2);
    poke(16'h0012, 16'd3); poke(16'h0013, 16'd4);
    wbase = wr_addr_log.size();
    launch(1'b0, 16'h0010, 16'h0012, 16'd4, 16'h0);
    wait_done(bc, got, pw);
    check("ovl_done_seen", got, 1);
    check("ovl_m12", mem[16'h0012], 16'd1);
    check("ovl_m13", mem[16'h0013], 16'd2);
    check("ovl_m14", mem[16'h0014], 16'd3);
    check("ovl_m15", mem[16'h0015], 16'd4);
    check("ovl_writes", wr_addr_log.size() - wbase, 4);
    exp_a[0] = 16'h0015; exp_a[1] = 16'h0014; exp_a[2] = 16'h0013; exp_a[3] = 16'h0012;
    for (int i = 0; i < 4; i++)
      check($sformatf("ovl_order%0d", i), wr_addr_log[wbase + i], exp_a[i]);

    // Fill across the top of the address space.
    wbase = wr_addr_log.size(); rbase = rd_cnt;
    launch(1'b1, 16'h0000, 16'hFFFE, 16'd4, 16'hBEEF);
    wait_done(bc, got, pw);
    check("fill_done_seen", got, 1);
    check("fill_busy_cycles", bc, 5);
    check("fill_write_before_done", pw, 1);
    check("fill_reads", rd_cnt - rbase, 0);
    check("fill_writes", wr_addr_log.size() - wbase, 4);
    exp_a[0] = 16'hFFFE; exp_a[1] = 16'hFFFF; exp_a[2] = 16'h0000; exp_a[3] = 16'h0001;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fill_order%0d", i), wr_addr_log[wbase + i], exp_a[i]);
      check($sformatf("fill_data%0d", i), mem[exp_a[i]], 16'hBEEF);
    end

    // Zero-length start: done with no memory traffic.
    wbase = wr_addr_log.size(); rbase = rd_cnt;
    launch(1'b0, 16'h0300, 16'h0400, 16'd0, 16'h0);
    check("len0_busy_first", busy, 1);
    check("len0_done_first", done, 0);
    wait_done(bc, got, pw);
    check("len0_done_seen", got, 1);
    check("len0_busy_cycles", bc, 1);
    check("len0_aborted", aborted, 0);
    repeat (3) @(negedge clk);
    check("len0_reads", rd_cnt - rbase, 0);
    check("len0_writes", wr_addr_log.size() - wbase, 0);

    // Abort during the third read-issue cycle of a long copy.
    wbase = wr_addr_log.size();
    launch(1'b0, 16'h0300, 16'h0400, 16'd100, 16'h0);
    nre = 0;
    for (int i = 0; i < 20 && nre < 3; i++) begin
      if (mem_re) nre++;
      if (nre < 3) @(negedge clk);
    end
    check("abort_reached_third_read", nre, 3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_re_dropped", mem_re, 0);
    check("abort_we_dropped", mem_we, 0);
    wait_done(bc, got, pw);
    check("abort_done_seen", got, 1);
    check("abort_flag", aborted, 1);
    repeat (3) @(negedge clk);
    check("abort_flag_holds", aborted, 1);
    check("abort_writes", wr_addr_log.size() - wbase, 2);

    // Reset in the middle of a copy: everything stops, no done.
    launch(1'b0, 16'h0500, 16'h0480, 16'd20, 16'h0);
    check("rstmid_aborted_cleared", aborted, 0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid_busy", busy, 0);
    check("rstmid_re", mem_re, 0);
    check("rstmid_we", mem_we, 0);
    wbase = wr_addr_log.size(); rbase = rd_cnt; dbase = done_cnt;
    repeat (30) @(negedge clk);
    check("rstmid_writes", wr_addr_log.size() - wbase, 0);
    check("rstmid_reads", rd_cnt - rbase, 0);
    check("rstmid_done", done_cnt - dbase, 0);

    check("done_busy_overlap", ovl_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
